stream_pattern_matcher: RTL and testbench
=========================================

Name: stream_pattern_matcher

Overview:
Serial-input, parametrised pattern matcher. It collects a frame of WIN_W bits, MSB first, from a valid/ready stream and compares it against a loadable PAT_W-bit pattern at every alignment. It reports a per-position hit vector, any-hit flag, hit count (overlapping or non-overlapping mode) and highest hit position through a valid/ready result port. A per-bit running match pulse is also provided. It replaces single-shot combinational 8-bit/4-bit matching in the string-search datapath.

Parameters:
WIN_W, 8, frame/window length in bits; legal range PAT_W <= WIN_W <= 64.
PAT_W, 4, pattern length in bits; legal range 1 <= PAT_W <= WIN_W.
Derived constants, not overridable:
- NPOS = WIN_W-PAT_W+1
- CNT_W = $clog2(NPOS+1)
- POS_W = max(1, $clog2(NPOS))

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  abort the current frame and result.
pat_load  in  1  load request for pat_in.
pat_in  in  PAT_W  new pattern.
load_err  out  1  one-cycle pulse: pat_load was ignored.
overlap_en  in  1  1 = overlapping count, 0 = non-overlapping (greedy from highest position).
in_valid  in  1  stream bit valid.
in_bit  in  1  stream bit.
in_ready  out  1  block accepts a bit.
match_pulse  out  1  registered; last PAT_W in-frame bits equal the pattern.
out_valid  out  1  frame result valid.
out_ready  in  1  result consumed.
hits  out  NPOS  hits[i] = (window[i+PAT_W-1:i] == pattern).
any_hit  out  1  |hits.
hit_count  out  CNT_W  count per mode.
first_pos  out  POS_W  highest i with hits[i]; 0 if none.

Behaviour:
- Reset (async, rst_n low):
  - state COLLECT; window, bit counter and pattern register 0.
  - match_pulse, load_err, out_valid, hits, any_hit, hit_count, first_pos all 0.
  - in_ready = (state==COLLECT), so it is 1 during and after reset.
- COLLECT:
  - Each cycle with in_valid&in_ready: window <= {window[WIN_W-2:0], in_bit}; cnt++.
  - On the accept that makes cnt==WIN_W: cnt <= 0 and state <= EVAL.
- match_pulse: asserted the cycle after an accept when in-frame bits (including this one) >= PAT_W and the new window[PAT_W-1:0] == pattern; otherwise 0. It never spans frames.
- EVAL (exactly 1 cycle):
  - in_ready=0.
  - Register hits, any_hit and first_pos.
  - hit_count:
    - overlap_en=1: popcount(hits).
    - overlap_en=0: scan i from NPOS-1 down to 0; count a hit, then skip the next PAT_W-1 lower positions.
  - overlap_en is sampled in EVAL only.
  - Next state REPORT.
- REPORT:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid&out_ready: out_valid <= 0, state <= COLLECT.
  - Latency: last bit accepted in cycle T -> out_valid in cycle T+2.
- pat_load:
  - Accepted only in COLLECT with cnt==0; pattern <= pat_in, effective the next cycle.
  - pat_load with an in_valid accept in the same cycle: load and bit both taken; the new pattern applies to that bit's match_pulse and to the frame.
  - pat_load in any other state or count: pattern unchanged; load_err=1 for the next cycle.
- flush (highest priority, synchronous):
  - Next cycle: state COLLECT, cnt 0, window 0, out_valid 0, match_pulse 0.
  - Pattern is retained; any in_valid bit in the flush cycle is dropped.
  - pat_load in the flush cycle is ignored, with no load_err.
- Width rules: all comparisons unsigned and exact width; hit_count never exceeds NPOS.
- PAT_W==WIN_W: NPOS=1; first_pos is always 0.

Decomposition:
- Package pm_pkg:
  - state enum {COLLECT, EVAL, REPORT} (2 bits).
  - Derived-constant functions for NPOS, CNT_W, POS_W.
- Sub-module pm_window_compare (purely combinational):
  - Inputs: window, pattern, overlap_en.
  - Outputs: hits, any_hit, hit_count, first_pos.
- Top level holds the FSM, counter, shift register, pattern register and handshakes.

Test Plan:
1. Defaults; load 1110; stream 11100011 -> hits=10000, any_hit=1, hit_count=1, first_pos=4; out_valid 2 cycles after the 8th bit.
2. Load 1010; stream 10111011 -> hits=00000, any_hit=0, hit_count=0, first_pos=0. Then stream 11101011 -> hits=00100, count=1, first_pos=2.
3. Pattern 1010, window 10101010:
   - overlap_en=1 -> hits=10101, count=3, first_pos=4.
   - overlap_en=0 -> count=2.
   - Also check match_pulse after in-frame bits 4, 6 and 8 only.
4. Backpressure: hold out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0, in_valid bits not consumed. Release -> in_ready=1 next cycle.
5. pat_load at cnt=3 -> load_err pulse, pattern unchanged. pat_load at cnt=0 simultaneous with the first bit -> new pattern used for the frame.
6. flush at cnt=5, then full frame 11100011 with pattern 1110 -> result as scenario 1. Assert rst_n low mid-REPORT -> out_valid=0 and pattern=0 immediately.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared types and derived-size helpers for the stream pattern matcher.
// NPOS is the number of pattern alignments that fit inside one frame.
package pm_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    REPORT  = 2'd2
  } state_t;

  function automatic int npos_f(input int win_w, input int pat_w);
    return win_w - pat_w + 1;
  endfunction

  function automatic int cnt_w_f(input int win_w, input int pat_w);
    return $clog2(npos_f(win_w, pat_w) + 1);
  endfunction

  // A single alignment still needs a 1-bit position field.
  function automatic int pos_w_f(input int win_w, input int pat_w);
    int n;
    n = npos_f(win_w, pat_w);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pm_window_compare.sv
// Combinational compare of a full frame against the pattern at every alignment,
// with hit count in overlapping or greedy non-overlapping mode.
module pm_window_compare
  import pm_pkg::*;
#(
  parameter int  WIN_W = 8,
  parameter int  PAT_W = 4,
  localparam int NPOS  = npos_f(WIN_W, PAT_W),
  localparam int CNT_W = cnt_w_f(WIN_W, PAT_W),
  localparam int POS_W = pos_w_f(WIN_W, PAT_W)
) (
  input  logic [WIN_W-1:0] window,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap_en,
  output logic [NPOS-1:0]  hits,
  output logic             any_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [POS_W-1:0] first_pos
);

  genvar gi;
  generate
    for (gi = 0; gi < NPOS; gi++) begin : g_pos
      assign hits[gi] = (window[gi+PAT_W-1 -: PAT_W] == pattern);
    end
  endgenerate

  assign any_hit = |hits;

  logic [CNT_W-1:0] pop_count;
  logic [CNT_W-1:0] greedy_count;
  int               skip;

  // Ascending scan leaves first_pos at the highest hit; the descending scan
  // claims a hit and then blanks the PAT_W-1 positions it overlaps.
  always_comb begin
    pop_count    = '0;
    greedy_count = '0;
    first_pos    = '0;
    skip         = 0;
    for (int i = 0; i < NPOS; i++) begin
      if (hits[i]) begin
        pop_count = pop_count + CNT_W'(1);
        first_pos = POS_W'(i);
      end
    end
    for (int i = NPOS - 1; i >= 0; i--) begin
      if (skip > 0) begin
        skip = skip - 1;
      end else if (hits[i]) begin
        greedy_count = greedy_count + CNT_W'(1);
        skip         = PAT_W - 1;
      end
    end
  end

  assign hit_count = overlap_en ? pop_count : greedy_count;

endmodule

// File: rtl/stream_pattern_matcher.sv
// Serial frame collector with a loadable pattern, a per-bit match pulse and
// a valid/ready result port carrying per-alignment hit information.
module stream_pattern_matcher
  import pm_pkg::*;
#(
  parameter int  WIN_W = 8,
  parameter int  PAT_W = 4,
  localparam int NPOS  = npos_f(WIN_W, PAT_W),
  localparam int CNT_W = cnt_w_f(WIN_W, PAT_W),
  localparam int POS_W = pos_w_f(WIN_W, PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             load_err,
  input  logic             overlap_en,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             match_pulse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NPOS-1:0]  hits,
  output logic             any_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [POS_W-1:0] first_pos
);

  localparam int                BCNT_W    = $clog2(WIN_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(WIN_W - 1);
  localparam logic [BCNT_W-1:0] MATCH_MIN = BCNT_W'(PAT_W - 1);

  state_t             state_reg, state_next;
  logic [BCNT_W-1:0]  cnt_reg, cnt_next;
  logic [WIN_W-1:0]   window_reg, window_next, window_shift;
  logic [PAT_W-1:0]   pattern_reg, pattern_next, pattern_eff;
  logic               match_pulse_reg, match_pulse_next;
  logic               load_err_reg, load_err_next;
  logic               out_valid_reg, out_valid_next;
  logic [NPOS-1:0]    hits_reg, hits_next;
  logic               any_hit_reg, any_hit_next;
  logic [CNT_W-1:0]   hit_count_reg, hit_count_next;
  logic [POS_W-1:0]   first_pos_reg, first_pos_next;

  logic [NPOS-1:0]    cmp_hits;
  logic               cmp_any;
  logic [CNT_W-1:0]   cmp_count;
  logic [POS_W-1:0]   cmp_pos;
  logic               accept;
  logic               load_ok;

  generate
    if (WIN_W == 1) begin : g_shift_one
      assign window_shift = in_bit;
    end else begin : g_shift_many
      assign window_shift = {window_reg[WIN_W-2:0], in_bit};
    end
  endgenerate

  assign in_ready = (state_reg == COLLECT);
  assign accept   = in_valid & in_ready & ~flush;
  assign load_ok  = pat_load & ~flush & (state_reg == COLLECT) & (cnt_reg == '0);
  // A load taken alongside the first bit must already govern that bit's compare.
  assign pattern_eff = load_ok ? pat_in : pattern_reg;

  pm_window_compare #(
    .WIN_W(WIN_W),
    .PAT_W(PAT_W)
  ) u_compare (
    .window    (window_reg),
    .pattern   (pattern_reg),
    .overlap_en(overlap_en),
    .hits      (cmp_hits),
    .any_hit   (cmp_any),
    .hit_count (cmp_count),
    .first_pos (cmp_pos)
  );

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    window_next      = window_reg;
    pattern_next     = pattern_eff;
    match_pulse_next = 1'b0;
    load_err_next    = pat_load & ~flush & ~load_ok;
    out_valid_next   = out_valid_reg;
    hits_next        = hits_reg;
    any_hit_next     = any_hit_reg;
    hit_count_next   = hit_count_reg;
    first_pos_next   = first_pos_reg;

    if (flush) begin
      state_next     = COLLECT;
      cnt_next       = '0;
      window_next    = '0;
      out_valid_next = 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            window_next      = window_shift;
            match_pulse_next = (cnt_reg >= MATCH_MIN) &&
                               (window_shift[PAT_W-1:0] == pattern_eff);
            if (cnt_reg == LAST_BIT) begin
              cnt_next   = '0;
              state_next = EVAL;
            end else begin
              cnt_next = cnt_reg + BCNT_W'(1);
            end
          end
        end
        EVAL: begin
          hits_next      = cmp_hits;
          any_hit_next   = cmp_any;
          hit_count_next = cmp_count;
          first_pos_next = cmp_pos;
          out_valid_next = 1'b1;
          state_next     = REPORT;
        end
        REPORT: begin
          if (out_ready) begin
            out_valid_next = 1'b0;
            state_next     = COLLECT;
          end
        end
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= COLLECT;
      cnt_reg         <= '0;
      window_reg      <= '0;
      pattern_reg     <= '0;
      match_pulse_reg <= 1'b0;
      load_err_reg    <= 1'b0;
      out_valid_reg   <= 1'b0;
      hits_reg        <= '0;
      any_hit_reg     <= 1'b0;
      hit_count_reg   <= '0;
      first_pos_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      window_reg      <= window_next;
      pattern_reg     <= pattern_next;
      match_pulse_reg <= match_pulse_next;
      load_err_reg    <= load_err_next;
      out_valid_reg   <= out_valid_next;
      hits_reg        <= hits_next;
      any_hit_reg     <= any_hit_next;
      hit_count_reg   <= hit_count_next;
      first_pos_reg   <= first_pos_next;
    end
  end

  assign match_pulse = match_pulse_reg;
  assign load_err    = load_err_reg;
  assign out_valid   = out_valid_reg;
  assign hits        = hits_reg;
  assign any_hit     = any_hit_reg;
  assign hit_count   = hit_count_reg;
  assign first_pos   = first_pos_reg;

endmodule

// File: tb/tb_stream_pattern_matcher.sv
// Directed bench for stream_pattern_matcher at WIN_W=8, PAT_W=4 with
// hand-computed hit vectors, counts and per-bit match pulses.
module tb_stream_pattern_matcher;

  localparam int WIN_W = 8;
  localparam int PAT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'd0;
  logic       load_err;
  logic       overlap_en = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_ready;
  logic       match_pulse;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] hits;
  logic       any_hit;
  logic [2:0] hit_count;
  logic [2:0] first_pos;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_pattern_matcher #(
    .WIN_W(WIN_W),
    .PAT_W(PAT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .load_err   (load_err),
    .overlap_en (overlap_en),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .match_pulse(match_pulse),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hits       (hits),
    .any_hit    (any_hit),
    .hit_count  (hit_count),
    .first_pos  (first_pos)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends bits[hi] down to bits[lo]; pulses[k] is the expected match_pulse after bits[k].
  task automatic send_bits(input logic [7:0] bits, input logic [7:0] pulses,
                           input int hi, input int lo, input string tag);
    for (int k = hi; k >= lo; k--) begin
      check($sformatf("%s_rdy%0d", tag, 8 - k), in_ready, 1'b1);
      in_valid = 1'b1;
      in_bit   = bits[k];
      tick;
      in_valid = 1'b0;
      pat_load = 1'b0;
      check($sformatf("%s_pulse%0d", tag, 8 - k), match_pulse, pulses[k]);
    end
  endtask

  task automatic finish_frame(input string tag);
    check({tag, "_eval_nvalid"}, out_valid, 1'b0);
    check({tag, "_eval_nrdy"}, in_ready, 1'b0);
    tick;
    check({tag, "_valid"}, out_valid, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] bits, input logic [7:0] pulses, input string tag);
    send_bits(bits, pulses, 7, 0, tag);
    finish_frame(tag);
  endtask

  task automatic check_result(input string tag, input logic [4:0] h, input logic a,
                              input logic [2:0] c, input logic [2:0] p);
    check({tag, "_hits"}, hits, h);
    check({tag, "_any"}, any_hit, a);
    check({tag, "_count"}, hit_count, c);
    check({tag, "_pos"}, first_pos, p);
    $display("result %s: hits=%b any=%0b count=%0d pos=%0d", tag, hits, any_hit, hit_count, first_pos);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_cons_nvalid"}, out_valid, 1'b0);
    check({tag, "_cons_rdy"}, in_ready, 1'b1);
  endtask

  task automatic load_pattern(input logic [3:0] p, input string tag);
    pat_load = 1'b1;
    pat_in   = p;
    tick;
    pat_load = 1'b0;
    check({tag, "_load_err"}, load_err, 1'b0);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_match", match_pulse, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    check("rst_hits", hits, 5'b0);
    check("rst_count", hit_count, 3'd0);
    check("rst_pos", first_pos, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // 1: pattern 1110, frame 11100011
    load_pattern(4'b1110, "s1");
    send_frame(8'b11100011, 8'b00010000, "s1");
    check_result("s1", 5'b10000, 1'b1, 3'd1, 3'd4);
    consume("s1");

    // 2: pattern 1010, miss frame then single hit at 2
    load_pattern(4'b1010, "s2");
    send_frame(8'b10111011, 8'b00000000, "s2a");
    check_result("s2a", 5'b00000, 1'b0, 3'd0, 3'd0);
    consume("s2a");
    send_frame(8'b11101011, 8'b00000100, "s2b");
    check_result("s2b", 5'b00100, 1'b1, 3'd1, 3'd2);
    consume("s2b");

    // 3: overlapping vs greedy non-overlapping count
    overlap_en = 1'b1;
    send_frame(8'b10101010, 8'b00010101, "s3a");
    check_result("s3a", 5'b10101, 1'b1, 3'd3, 3'd4);
    consume("s3a");
    overlap_en = 1'b0;
    send_frame(8'b10101010, 8'b00010101, "s3b");
    check_result("s3b", 5'b10101, 1'b1, 3'd2, 3'd4);

    // 4: backpressure; overlap_en change in REPORT must not alter the result
    overlap_en = 1'b1;
    in_valid   = 1'b1;
    in_bit     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      check($sformatf("s4_valid%0d", c), out_valid, 1'b1);
      check($sformatf("s4_nrdy%0d", c), in_ready, 1'b0);
      check($sformatf("s4_hits%0d", c), hits, 5'b10101);
      check($sformatf("s4_count%0d", c), hit_count, 3'd2);
    end
    in_valid = 1'b0;
    consume("s4");
    $display("backpressure: held 5 cycles, released");

    // 5a: load at cnt=3 rejected, pattern stays 1010
    send_bits(8'b10101010, 8'b00010101, 7, 5, "s5a");
    pat_load = 1'b1;
    pat_in   = 4'b0000;
    tick;
    pat_load = 1'b0;
    check("s5a_load_err", load_err, 1'b1);
    tick;
    check("s5a_load_err_clr", load_err, 1'b0);
    send_bits(8'b10101010, 8'b00010101, 4, 0, "s5a");
    finish_frame("s5a");
    check_result("s5a", 5'b10101, 1'b1, 3'd3, 3'd4);
    consume("s5a");

    // 5b: load together with the first bit applies to the whole frame
    pat_load = 1'b1;
    pat_in   = 4'b0011;
    send_bits(8'b00110011, 8'b00010001, 7, 7, "s5b");
    check("s5b_load_err", load_err, 1'b0);
    send_bits(8'b00110011, 8'b00010001, 6, 0, "s5b");
    finish_frame("s5b");
    check_result("s5b", 5'b10001, 1'b1, 3'd2, 3'd4);
    consume("s5b");

    // 6: flush at cnt=5 drops the bit and the load, keeps pattern 0011
    send_bits(8'b10101000, 8'b00000000, 7, 3, "s6a");
    flush    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    pat_load = 1'b1;
    pat_in   = 4'b1111;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    pat_load = 1'b0;
    check("s6_flush_load_err", load_err, 1'b0);
    check("s6_flush_match", match_pulse, 1'b0);
    check("s6_flush_rdy", in_ready, 1'b1);
    check("s6_flush_valid", out_valid, 1'b0);
    send_frame(8'b00110011, 8'b00010001, "s6b");
    check_result("s6b", 5'b10001, 1'b1, 3'd2, 3'd4);
    consume("s6b");
    pat_load = 1'b1;
    pat_in   = 4'b1110;
    send_frame(8'b11100011, 8'b00010000, "s6c");
    check_result("s6c", 5'b10000, 1'b1, 3'd1, 3'd4);

    // Async reset mid-REPORT clears outputs without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_arst_valid", out_valid, 1'b0);
    check("s6_arst_hits", hits, 5'b0);
    check("s6_arst_count", hit_count, 3'd0);
    check("s6_arst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    // Pattern reset to 0000: an all-zero frame hits everywhere
    send_frame(8'b00000000, 8'b00011111, "s6d");
    check_result("s6d", 5'b11111, 1'b1, 3'd5, 3'd4);
    consume("s6d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
